// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue handshake bundle: push side from fetch, pop side to decode.
// Ports: push_valid/ready/pc/instr/exc, pop_valid/ready/pc/instr/exc.
interface if_id_queue_if;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic [3:0]  push_exc;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_pc;
  logic [31:0] pop_instr;
  logic [3:0]  pop_exc;

  modport master (
    output push_valid, push_pc, push_instr, push_exc, pop_ready,
    input  push_ready, pop_valid, pop_pc, pop_instr, pop_exc
  );

  modport slave (
    input  push_valid, push_pc, push_instr, push_exc, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_instr, pop_exc
  );
endinterface

// File: rtl/if_id_queue.sv
// IF->ID instruction queue: DEPTH entries of {pc, instr, exc}, flush clears,
// holds off fetch after a faulting entry until flush.
// Ports: clk, rst (sync, active-high), flush, count, bus (slave modport).
// Optional IF_ID_QUEUE_BYPASS_EN: empty-queue push is visible to decode same cycle.
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  if_id_queue_if.slave           bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    RUN,
    HOLD
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [3:0]  exc_mem   [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  logic        push_fire;
  logic        pop_fire;
  logic        byp;
  logic        wr_en;
  logic        rd_en;
  logic        push_fault;
  logic [31:0] push_instr_m;

  assign push_fault   = bus.push_exc != 4'd0;
  assign push_instr_m = push_fault ? 32'd0 : bus.push_instr;

  assign bus.push_ready = (count != FULL) & (state == RUN) & ~flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign byp = (count == '0) & (state == RUN) & ~flush & bus.push_valid;
`else
  assign byp = 1'b0;
`endif

  assign bus.pop_valid = (count != '0) | byp;

  always_comb begin
    bus.pop_pc    = pc_mem[rptr];
    bus.pop_instr = instr_mem[rptr];
    bus.pop_exc   = exc_mem[rptr];
    if (byp) begin
      bus.pop_pc    = bus.push_pc;
      bus.pop_instr = push_instr_m;
      bus.pop_exc   = bus.push_exc;
    end
  end

  assign push_fire = bus.push_valid & bus.push_ready;
  assign pop_fire  = bus.pop_valid & bus.pop_ready;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign wr_en = push_fire & ~(byp & bus.pop_ready);
  assign rd_en = pop_fire & ~byp;

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:  if (push_fire & push_fault) state_nx = HOLD;
      HOLD: state_nx = HOLD;
      default: state_nx = RUN;
    endcase
    if (flush) state_nx = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      state <= RUN;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
        exc_mem[i]   <= '0;
      end
    end else if (wr_en) begin
      pc_mem[wptr]    <= bus.push_pc;
      instr_mem[wptr] <= push_instr_m;
      exc_mem[wptr]   <= bus.push_exc;
    end
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and the decode stage. Accepts one fetched instruction per cycle, with its PC and fetch exception code, and presents entries in order to decode through a valid/ready handshake. The queue decouples fetch stalls (cache miss, uncached access) from decode stalls. It is cleared by a flush on redirects: branch, jump, ERET, exception entry, TLB refill. After accepting a faulting fetch, it stops accepting further fetches until the next flush.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- push_valid  in  1  fetch holds a new instruction (fetch not stalled, new PC)
- push_ready  out  1  queue can accept this cycle
- push_pc  in  32  PC of fetched instruction
- push_instr  in  32  instruction word
- push_exc  in  4  fetch exception code; 0 = none (e.g. EXP_ITLBR, EXP_ITLBI)
- flush  in  1  discard all entries and pending push; clear hold
- pop_valid  out  1  head entry available
- pop_ready  in  1  decode consumes head this cycle
- pop_pc  out  32  head PC
- pop_instr  out  32  head instruction
- pop_exc  out  4  head exception code
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH entries of {pc, instr, exc}, i.e. 68 bits each. Write pointer wptr and read pointer rptr, each $clog2(DEPTH) bits, wrap modulo DEPTH. count tracks occupancy from 0 to DEPTH.
- push_fire = push_valid & push_ready. pop_fire = pop_valid & pop_ready.
- push_ready = (count != DEPTH) & (state == RUN) & ~flush.
- pop_valid = (count != 0). pop_* is driven combinationally from entry[rptr].
- push_fire writes entry[wptr] and increments wptr. pop_fire increments rptr.
- count update: +1 on push only, −1 on pop only, unchanged when both fire.
- Entries with push_exc != 0 store instr = 0, regardless of push_instr.
- State machine:
  - RUN → HOLD when push_fire with push_exc != 0. The faulting entry is still stored.
  - HOLD: push_ready = 0. Draining through pop continues normally.
  - HOLD → RUN on flush only.
  - Any state → RUN on rst.
- Flush takes priority over everything:
  - Next cycle: wptr = rptr = count = 0 and state = RUN.
  - A push presented in the flush cycle is not written.
  - A pop in the flush cycle is seen by decode, but decode must ignore it because decode is flushed too.
- Full with simultaneous pop: push_ready stays 0. There is no same-cycle pass-through when full.
- Empty: pop_valid = 0. pop_* shows entry[rptr] (stale); decode must not use it.

## Timing
- Reset values: push_ready = 1, pop_valid = 0, count = 0, pop_pc = pop_instr = 0, pop_exc = 0. All storage is cleared to 0 and state = RUN.
- Latency without bypass: an entry pushed in cycle N is poppable in cycle N+1.
- Throughput: one push and one pop per cycle.
- push_ready depends only on registered state and flush. There is no combinational path from pop_ready to push_ready.
- Flush asserted in cycle N: pop_valid = 0 and push_ready = 1 in cycle N+1.
- rst asserted mid-operation discards all entries and holds the same as flush, and also clears storage.

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined:
  - When count == 0, state == RUN, ~flush and push_valid: pop_valid = 1 and pop_* = push data in the same cycle, with exc masking applied.
  - If pop_ready is also high, the entry is not written and count stays 0. A faulting entry consumed this way still moves state to HOLD.
  - Adds a combinational path from push_* to pop_*.
- Not defined: pop_* always comes from storage, with a minimum latency of 1 cycle.

## Test plan
- Reset, then push PC 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive cycles with pop_ready = 0 → count = 3, and the head is 0xbfc00000. Set pop_ready = 1 → PCs come out in order, and count returns to 0.
- Fill DEPTH = 4 entries with pop_ready = 0 → push_ready = 0 at count = 4. Push and pop on the same cycle at count = 2 → count stays 2. Run a push/pop stream through pointer wrap → output order is preserved.
- Push with push_exc = EXP_ITLBR, push_instr = 0x24010001 → the stored entry has instr = 0 and exc = EXP_ITLBR, and push_ready = 0 afterwards. Queue drains normally, then flush → push_ready = 1.
- Flush while count = 3 and push_valid = 1 in the same cycle → next cycle count = 0 and pop_valid = 0. The flushed push never appears at the output.
- Assert rst mid-stream with count = 2 → next cycle all outputs are at their reset values.
- With IF_ID_QUEUE_BYPASS_EN: empty queue, push 0xbfc00380 with pop_ready = 1 → pop_valid = 1 and pop_pc = 0xbfc00380 in the same cycle, count stays 0. Without the macro: pop_valid rises one cycle later.
